// File: rtl/mobo_mem_responder_pkg.sv
// Shared constants for the motherboard memory responder: command codes,
// status bit positions and FSM state encodings used by both CPU and board side.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package mobo_mem_responder_pkg;

    localparam int MOBO_WORD_WIDTH = `WORD_WIDTH;

    localparam logic [1:0] MOBO_CMD_NONE    = 2'b00;
    localparam logic [1:0] MOBO_CMD_READ    = 2'b01;
    localparam logic [1:0] MOBO_CMD_WRITE   = 2'b10;
    localparam logic [1:0] MOBO_CMD_ILLEGAL = 2'b11;

    localparam int MOBO_STAT_BUSY = 0;
    localparam int MOBO_STAT_DONE = 1;
    localparam int MOBO_STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mobo_state_t;

endpackage

// File: rtl/mobo_mem_responder_array.sv
// Single-port synchronous word array with a one-cycle registered read.
// Contents are deliberately not reset.
module mobo_mem_array #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  idx,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mobo_mem_responder.sv
// Motherboard-side responder for the CPU mobo_ctrl/mobo_stat bus: latches a
// command, inserts wait states, accesses the word array and handshakes DONE.
module mobo_mem_responder
    import mobo_mem_responder_pkg::*;
#(
    parameter int WORD_WIDTH  = MOBO_WORD_WIDTH,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] mobo_ctrl,
    output logic [WORD_WIDTH-1:0] mobo_stat,
    input  logic [WORD_WIDTH-1:0] addr_in,
    input  logic [WORD_WIDTH-1:0] mobodat_in,
    output logic [WORD_WIDTH-1:0] mobodat_out
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

    mobo_state_t           state;
    logic [7:0]            cnt;
    logic [1:0]            cmd_q;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  rd_pending;
    logic [WORD_WIDTH-1:0] rdata;
    logic [ADDR_BITS-1:0]  idx;
    logic                  in_range;
    logic                  mem_we;
    logic                  unused_ctrl_bits;

    assign unused_ctrl_bits = ^mobo_ctrl[WORD_WIDTH-1:2];
    assign idx      = addr_q[ADDR_BITS-1:0];
    assign in_range = ((addr_q >> ADDR_BITS) == '0);
    assign mem_we   = (state == ST_ACCESS) && (cmd_q == MOBO_CMD_WRITE) && in_range;

    mobo_mem_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx),
        .wdata (data_q),
        .rdata (rdata)
    );

    // Status is registered from the current state, so it trails the FSM by one
    // cycle; this also lines up the read data with the first DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cmd_q       <= MOBO_CMD_NONE;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            rd_pending  <= 1'b0;
            mobo_stat   <= '0;
            mobodat_out <= '0;
        end else begin
            rd_pending <= 1'b0;
            mobo_stat  <= '0;
            if (rd_pending) begin
                mobodat_out <= rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (mobo_ctrl[1:0] != MOBO_CMD_NONE) begin
                        cmd_q  <= mobo_ctrl[1:0];
                        addr_q <= addr_in;
                        data_q <= mobodat_in;
                        err_q  <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    mobo_stat[MOBO_STAT_BUSY] <= 1'b1;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mobo_stat[MOBO_STAT_BUSY] <= 1'b1;
                    err_q      <= (cmd_q == MOBO_CMD_ILLEGAL) || !in_range;
                    rd_pending <= (cmd_q == MOBO_CMD_READ) && in_range;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    mobo_stat[MOBO_STAT_DONE] <= 1'b1;
                    mobo_stat[MOBO_STAT_ERR]  <= err_q;
                    if (mobo_ctrl[1:0] == MOBO_CMD_NONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Self-checking bench for mobo_mem_responder: table-driven transfers with a
// scoreboard queue, plus hand sequences for early drop, reset and zero wait.
module tb_mobo_mem_responder;
    import mobo_mem_responder_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] mobo_ctrl, mobo_stat, addr_in, mobodat_in, mobodat_out;
    logic [W-1:0] ctrl0, stat0, addr0, din0, dout0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         err;
        logic [W-1:0] out;
    } exp_t;

    typedef struct {
        logic [W-1:0] ctrl;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic         err;
        logic [W-1:0] out;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    mobo_mem_responder #(.WORD_WIDTH(W), .ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .mobo_ctrl   (mobo_ctrl),
        .mobo_stat   (mobo_stat),
        .addr_in     (addr_in),
        .mobodat_in  (mobodat_in),
        .mobodat_out (mobodat_out)
    );

    mobo_mem_responder #(.WORD_WIDTH(W), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .mobo_ctrl   (ctrl0),
        .mobo_stat   (stat0),
        .addr_in     (addr0),
        .mobodat_in  (din0),
        .mobodat_out (dout0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] cur_stat(input bit fast);
        return fast ? stat0 : mobo_stat;
    endfunction

    function automatic logic [W-1:0] cur_out(input bit fast);
        return fast ? dout0 : mobodat_out;
    endfunction

    // One full transfer: drive, wait for DONE within a bound, compare, release.
    task automatic run_xfer(input vec_t v, input bit fast);
        int   n;
        int   busy;
        exp_t e;
        e.err = v.err;
        e.out = v.out;
        sb.push_back(e);
        if (fast) begin
            ctrl0 = v.ctrl; addr0 = v.addr; din0 = v.data;
        end else begin
            mobo_ctrl = v.ctrl; addr_in = v.addr; mobodat_in = v.data;
        end
        tick();
        check("stat_after_accept", 32'(cur_stat(fast)), 32'h0);
        n = 0;
        busy = 0;
        do begin
            tick();
            n++;
            if (cur_stat(fast) == 16'h0001) busy++;
        end while (!cur_stat(fast)[MOBO_STAT_DONE] && n < 20);
        check("done_latency", 32'(n), fast ? 32'd2 : 32'd4);
        check("busy_cycles", 32'(busy), fast ? 32'd1 : 32'd3);
        e = sb.pop_front();
        check("err_bit", 32'(cur_stat(fast)[MOBO_STAT_ERR]), 32'(e.err));
        check("busy_clear_in_done", 32'(cur_stat(fast)[MOBO_STAT_BUSY]), 32'h0);
        check("read_data", 32'(cur_out(fast)), 32'(e.out));
        if (fast) ctrl0 = '0; else mobo_ctrl = '0;
        tick();
        tick();
        check("idle_stat", 32'(cur_stat(fast)), 32'h0);
        check("read_data_hold", 32'(cur_out(fast)), 32'(e.out));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   done_cnt;
        int   first_done;
        vec_t v;

        vecs = '{
            '{16'h0002, 16'h0005, 16'd10,   1'b0, 16'h0000},
            '{16'h0001, 16'h0005, 16'h0000, 1'b0, 16'd10},
            '{16'h0001, 16'h0105, 16'h0000, 1'b1, 16'd10},
            '{16'h0001, 16'h0005, 16'h0000, 1'b0, 16'd10},
            '{16'h0003, 16'h0005, 16'h0055, 1'b1, 16'd10},
            '{16'hA5A1, 16'h0005, 16'h0000, 1'b0, 16'd10},
            '{16'h0002, 16'h0007, 16'h0022, 1'b0, 16'd10},
            '{16'h0002, 16'h00FF, 16'hABCD, 1'b0, 16'd10},
            '{16'h0001, 16'h00FF, 16'h0000, 1'b0, 16'hABCD},
            '{16'h0002, 16'h0000, 16'h1111, 1'b0, 16'hABCD},
            '{16'h0002, 16'h8000, 16'hDEAD, 1'b1, 16'hABCD},
            '{16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h1111}
        };

        mobo_ctrl = '0; addr_in = '0; mobodat_in = '0;
        ctrl0 = '0; addr0 = '0; din0 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stat", 32'(mobo_stat), 32'h0);
        check("reset_out", 32'(mobodat_out), 32'h0);
        check("reset_stat_fast", 32'(stat0), 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_xfer(vecs[i], 1'b0);
        end

        // Early drop during WAIT with address/data changed afterwards
        mobo_ctrl = 16'h0002; addr_in = 16'h0006; mobodat_in = 16'd7;
        tick();
        mobo_ctrl = '0; addr_in = 16'h0007; mobodat_in = 16'd9;
        done_cnt = 0;
        first_done = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mobo_stat[MOBO_STAT_DONE]) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
        end
        check("early_drop_done_pulse", 32'(done_cnt), 32'd1);
        check("early_drop_done_edge", 32'(first_done), 32'd4);
        check("early_drop_idle", 32'(mobo_stat), 32'h0);
        v = '{16'h0001, 16'h0006, 16'h0000, 1'b0, 16'd7};
        run_xfer(v, 1'b0);
        v = '{16'h0001, 16'h0007, 16'h0000, 1'b0, 16'h0022};
        run_xfer(v, 1'b0);

        // Reset asserted in WAIT of a write must cancel it asynchronously
        mobo_ctrl = 16'h0002; addr_in = 16'h0005; mobodat_in = 16'd3;
        tick();
        tick();
        check("busy_before_reset", 32'(mobo_stat), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_stat", 32'(mobo_stat), 32'h0);
        mobo_ctrl = '0;
        tick();
        rst = 1'b1;
        tick();
        v = '{16'h0001, 16'h0005, 16'h0000, 1'b0, 16'd10};
        run_xfer(v, 1'b0);

        // Zero wait-state build
        v = '{16'h0002, 16'h0003, 16'h0044, 1'b0, 16'h0000};
        run_xfer(v, 1'b1);
        v = '{16'h0001, 16'h0003, 16'h0000, 1'b0, 16'h0044};
        run_xfer(v, 1'b1);
        v = '{16'h0001, 16'h0103, 16'h0000, 1'b1, 16'h0044};
        run_xfer(v, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mobo_mem_responder.md
Name: mobo_mem_responder

Overview:
- Motherboard-side responder for the CPU memory bus. It is the other end of the CPU's mobo_ctrl/mobo_stat request interface.
- Accepts read and write commands issued on mobo_ctrl with an address and write data, and services them against an internal word array after a configurable number of wait states.
- Reports progress on mobo_stat and completes each transfer with a four-phase done handshake.
- Sits on the motherboard between the CPU and the memory, and stands in for RAM in CPU simulation.

Parameters:
- WORD_WIDTH, `WORD_WIDTH, width of the ctrl, stat, address and data words.
- ADDR_BITS, 8, number of array index bits; DEPTH = 2**ADDR_BITS words.
- WAIT_CYCLES, 2, wait states inserted before the array access; range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mobo_ctrl  in  WORD_WIDTH  command from the CPU; bits[1:0] carry the command, upper bits are ignored.
- mobo_stat  out  WORD_WIDTH  status to the CPU: bit0 BUSY, bit1 DONE, bit2 ERR; all other bits 0.
- addr_in  in  WORD_WIDTH  address from the CPU address register.
- mobodat_in  in  WORD_WIDTH  write data from the CPU.
- mobodat_out  out  WORD_WIDTH  read data to the CPU.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-low.
- Reset values: state IDLE, mobo_stat = 0, mobodat_out = 0, wait counter 0. Array contents are not reset.
- Command encoding (bits[1:0]): 00 NONE, 01 READ, 10 WRITE, 11 ILLEGAL.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - mobo_stat = 0.
  - On a clock edge where the command is not NONE: latch the command, addr_in and mobodat_in.
  - If WAIT_CYCLES = 0, go to ACCESS; otherwise load cnt = WAIT_CYCLES and go to WAIT.
- WAIT:
  - BUSY = 1; cnt decrements each cycle.
  - Go to ACCESS on the edge where cnt == 1.
- ACCESS:
  - BUSY = 1.
  - READ: mobodat_out <= mem[idx].
  - WRITE: mem[idx] <= latched data.
  - Always go to DONE next.
- DONE:
  - BUSY = 0, DONE = 1; ERR as computed during ACCESS.
  - Hold while mobo_ctrl[1:0] != NONE.
  - When the command is NONE, return to IDLE on the next edge. DONE is therefore visible for at least one cycle.
- Latency: with the command sampled at edge 0, DONE is visible after edge WAIT_CYCLES+2; with the default, that is after edge 4.
- mobodat_out keeps the last successfully read value; it changes only in ACCESS on a valid READ.
- Index and range rules:
  - idx = latched address [ADDR_BITS-1:0].
  - If any address bit at or above ADDR_BITS is set: out of range. ERR = 1, no array access, mobodat_out unchanged.
- ILLEGAL command: passes through WAIT and ACCESS with no access, then DONE with ERR = 1.
- The command, address and data inputs are ignored from WAIT until the return to IDLE, because everything is latched at acceptance.
- If the command drops to NONE before DONE, the operation still completes. DONE is then shown for exactly one cycle and the FSM returns to IDLE.
- A new command is accepted only in IDLE. Back-to-back transfers therefore need the CPU to drop to NONE for at least one cycle.
- Reset mid-operation: immediate return to IDLE with stat 0. A write whose ACCESS edge has not yet occurred is not performed.

Decomposition:
- Shared constants go in mobo_states.v so the CPU read/write functions use identical values:
  - command codes MOBO_CMD_NONE/READ/WRITE/ILLEGAL;
  - stat bit indices MOBO_STAT_BUSY/DONE/ERR;
  - FSM state encodings.
- Sub-module: mobo_mem_array. It is a single-port synchronous array with we, idx, wdata and rdata, a one-cycle read, and is parameterised by WORD_WIDTH and ADDR_BITS.

Test Plan:
- Reset, then WRITE 10 to addr 0x05, hold until DONE, then drop to NONE -> BUSY for 3 cycles, DONE after edge 4, ERR = 0, IDLE one cycle after NONE.
- READ addr 0x05 after the write -> mobodat_out = 10 with DONE = 1, ERR = 0; mobodat_out remains 10 after returning to IDLE.
- READ addr 0x105 with ADDR_BITS = 8 -> DONE with ERR = 1, mobodat_out unchanged; a follow-up READ of 0x05 still returns 10.
- Command 11 -> DONE with ERR = 1, no array change (READ of 0x05 still returns 10). Separately, WAIT_CYCLES = 0 build: DONE visible after edge 2.
- WRITE 7 to addr 0x06; change addr_in to 0x07 and data to 9 during WAIT, and drop to NONE during WAIT -> one-cycle DONE pulse; mem[6] = 7, mem[7] unchanged.
- Assert rst in WAIT of a WRITE 3 to addr 0x05 -> stat = 0 immediately and asynchronously; after release, READ 0x05 returns 10.
